// File: rtl/fib_pkg.sv
// -----------------------------------------------------------------------------
// fib_pkg
// Shared definitions for the Fibonacci sequence generator:
//   - FSM state encoding (2-bit): ST_IDLE, ST_EMIT, ST_WAIT, ST_HALT
//   - overflow policy constants: MODE_WRAP (0), MODE_HALT (1)
//   - helper to decode the "busy" states
// -----------------------------------------------------------------------------
package fib_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_WAIT = 2'd2,
    ST_HALT = 2'd3
  } fib_state_e;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_HALT = 1'b1;

  // A sequence is in progress while a term is offered or the gap timer runs.
  function automatic logic fib_is_busy(input fib_state_e s);
    return (s == ST_EMIT) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/fib_tick_timer.sv
// -----------------------------------------------------------------------------
// fib_tick_timer
// Loadable down-counter that measures the idle gap between an accepted term
// and the next one. It counts down once per clock and parks at zero.
//
// Ports:
//   clock_in   : system clock, rising edge
//   reset_in   : asynchronous, active-low reset (counter -> 0)
//   load_in    : load value_in into the counter (priority over counting)
//   value_in   : reload value, TICK_WIDTH bits
//   expire_out : high while the counter is zero
// -----------------------------------------------------------------------------
module fib_tick_timer
  import fib_pkg::*;
#(
  parameter int unsigned TICK_WIDTH = 24
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  load_in,
  input  logic [TICK_WIDTH-1:0] value_in,
  output logic                  expire_out
);

  logic [TICK_WIDTH-1:0] count_q;
  logic [TICK_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_in) begin
      count_d = value_in;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_out = (count_q == '0);

endmodule

// File: rtl/fib_seq_gen.sv
// -----------------------------------------------------------------------------
// fib_seq_gen
// Parametrised Fibonacci term generator with a valid/ready output handshake,
// programmable gap between terms, programmable seeds, a wrap/halt overflow
// policy, start/stop control and a running term index.
//
// Optional build macro: FIB_SEQ_LED_EN adds led_out[3:0], a registered copy of
// term_out[3:0] that updates on the same edge as term_out.
//
// Ports:
//   clock_in       : system clock, rising edge
//   reset_in       : asynchronous, active-low reset
//   start_in       : begin a sequence (accepted in IDLE or HALT)
//   stop_in        : abort to IDLE (wins over start_in)
//   mode_in        : 0 = wrap on overflow, 1 = halt on overflow (latched at start)
//   period_in      : idle cycles between a handshake and the next term (latched)
//   term_out       : current term
//   term_valid_out : term_out is valid
//   term_ready_in  : consumer accepts term_out
//   index_out      : index of term_out (0 = SEED0), wraps modulo 2^IDX_WIDTH
//   overflow_out   : sticky, sequence exceeded DATA_WIDTH
//   busy_out       : high in EMIT / WAIT
//   led_out        : (FIB_SEQ_LED_EN only) term_out[3:0]
// -----------------------------------------------------------------------------
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TICK_WIDTH = 24,
  parameter int unsigned IDX_WIDTH  = 8,
  parameter int unsigned SEED0      = 0,
  parameter int unsigned SEED1      = 1
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  start_in,
  input  logic                  stop_in,
  input  logic                  mode_in,
  input  logic [TICK_WIDTH-1:0] period_in,
  output logic [DATA_WIDTH-1:0] term_out,
  output logic                  term_valid_out,
  input  logic                  term_ready_in,
  output logic [IDX_WIDTH-1:0]  index_out,
  output logic                  overflow_out,
  output logic                  busy_out
`ifdef FIB_SEQ_LED_EN
  ,
  output logic [3:0]            led_out
`endif
);

  localparam logic [DATA_WIDTH-1:0] SEED0_V = DATA_WIDTH'(SEED0);
  localparam logic [DATA_WIDTH-1:0] SEED1_V = DATA_WIDTH'(SEED1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  fib_state_e            state_q,  state_d;
  logic                  mode_q,   mode_d;
  logic [TICK_WIDTH-1:0] period_q, period_d;
  logic                  pend_q,   pend_d;    // last add carried out
  logic                  reload_q, reload_d;  // next emitted term restarts at index 0
  logic [DATA_WIDTH-1:0] term_q,   term_d;
  logic [IDX_WIDTH-1:0]  idx_q,    idx_d;
  logic                  ovf_q,    ovf_d;

  // ab_q[0] = a (next term to emit), ab_q[1] = b (the one after)
  logic [DATA_WIDTH-1:0] ab_q [2];
  logic [DATA_WIDTH-1:0] ab_d [2];

  logic [DATA_WIDTH:0]   sum;
  logic                  timer_load;
  logic                  timer_expire;

  // ---------------------------------------------------------------------------
  // Term registers a / b, each resetting to its own seed
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_reg
      localparam logic [DATA_WIDTH-1:0] RST_V = (gi == 0) ? SEED0_V : SEED1_V;
      logic [DATA_WIDTH-1:0] r_q;

      always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
          r_q <= RST_V;
        end else begin
          r_q <= ab_d[gi];
        end
      end

      assign ab_q[gi] = r_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Inter-term gap timer, loaded with the latched period at each handshake
  // ---------------------------------------------------------------------------
  fib_tick_timer #(
    .TICK_WIDTH (TICK_WIDTH)
  ) u_timer (
    .clock_in   (clock_in),
    .reset_in   (reset_in),
    .load_in    (timer_load),
    .value_in   (period_q),
    .expire_out (timer_expire)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    period_d   = period_q;
    pend_d     = pend_q;
    reload_d   = reload_q;
    term_d     = term_q;
    idx_d      = idx_q;
    ovf_d      = ovf_q;
    ab_d[0]    = ab_q[0];
    ab_d[1]    = ab_q[1];
    timer_load = 1'b0;
    sum        = {1'b0, ab_q[0]} + {1'b0, ab_q[1]};

    if (stop_in) begin
      // Abort: outputs other than valid/busy keep their last value.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALT: begin
          if (start_in) begin
            state_d  = ST_EMIT;
            mode_d   = mode_in;
            period_d = period_in;
            ab_d[0]  = SEED0_V;
            ab_d[1]  = SEED1_V;
            term_d   = SEED0_V;
            idx_d    = '0;
            ovf_d    = 1'b0;
            pend_d   = 1'b0;
            reload_d = 1'b0;
          end
        end

        ST_EMIT: begin
          if (term_ready_in) begin
            ab_d[0] = ab_q[1];
            ab_d[1] = sum[DATA_WIDTH-1:0];
            pend_d  = sum[DATA_WIDTH];
            if (pend_q) begin
              // The term just accepted was the last representable one.
              ovf_d = 1'b1;
              if (mode_q == MODE_HALT) begin
                state_d = ST_HALT;
              end else begin
                ab_d[0]    = SEED0_V;
                ab_d[1]    = SEED1_V;
                pend_d     = 1'b0;
                reload_d   = 1'b1;
                state_d    = ST_WAIT;
                timer_load = 1'b1;
              end
            end else begin
              state_d    = ST_WAIT;
              timer_load = 1'b1;
            end
          end
        end

        ST_WAIT: begin
          if (timer_expire) begin
            term_d   = ab_q[0];
            // After a wrap reload the restarted sequence begins at index 0.
            idx_d    = reload_q ? '0 : idx_q + 1'b1;
            reload_d = 1'b0;
            state_d  = ST_EMIT;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control / output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_WRAP;
      period_q <= '0;
      pend_q   <= 1'b0;
      reload_q <= 1'b0;
      term_q   <= '0;
      idx_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      pend_q   <= pend_d;
      reload_q <= reload_d;
      term_q   <= term_d;
      idx_q    <= idx_d;
      ovf_q    <= ovf_d;
    end
  end

  // Valid is exactly "in EMIT", so it can only fall through a handshake,
  // stop or reset.
  assign term_out       = term_q;
  assign term_valid_out = (state_q == ST_EMIT);
  assign index_out      = idx_q;
  assign overflow_out   = ovf_q;
  assign busy_out       = fib_is_busy(state_q);

`ifdef FIB_SEQ_LED_EN
  logic [3:0] led_q;

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      led_q <= 4'h0;
    end else begin
      // Size cast zero-extends when DATA_WIDTH < 4.
      led_q <= 4'(term_d);
    end
  end

  assign led_out = led_q;
`endif

endmodule

// File: doc/fib_seq_gen.md
Name: fib_seq_gen

Overview:
- Parametrised Fibonacci sequence generator. Successor to the fixed 4-bit, LED-only Fibonacci demo.
- Generalised data width, programmable inter-term period and seeds.
- Adds a valid/ready output handshake, an overflow policy (wrap or halt), a start/stop control interface and a term index.
- Sits between board-level control (buttons, UART, CPU regs) and any consumer of terms: LED driver, display, FIFO.

Parameters:
- DATA_WIDTH, 8, term width in bits (>=2).
- TICK_WIDTH, 24, width of period counter and period_in.
- IDX_WIDTH, 8, width of index_out; wraps modulo 2^IDX_WIDTH.
- SEED0, 0, first term (must fit DATA_WIDTH).
- SEED1, 1, second term (must fit DATA_WIDTH).

Ports:
- clock_in  input  1  system clock; all state on rising edge.
- reset_in  input  1  asynchronous, active-low reset.
- start_in  input  1  begin sequence; honoured in IDLE/HALT only.
- stop_in  input  1  abort to IDLE; priority over start_in.
- mode_in  input  1  0 = wrap on overflow, 1 = halt on overflow; latched at start.
- period_in  input  TICK_WIDTH  idle cycles between handshake and next term; latched at start.
- term_out  output  DATA_WIDTH  current term.
- term_valid_out  output  1  term_out valid.
- term_ready_in  input  1  consumer accepts term.
- index_out  output  IDX_WIDTH  index of term_out (0 = SEED0).
- overflow_out  output  1  sticky; set when the sequence exceeded DATA_WIDTH.
- busy_out  output  1  high in EMIT/WAIT.

Behaviour:
- Reset (reset_in=0, async): state IDLE; term_out=0, term_valid_out=0, index_out=0, overflow_out=0, busy_out=0; a=SEED0, b=SEED1, pend_ovf=0, timer=0.
- States:
  - IDLE: start_in -> latch mode/period; a=SEED0, b=SEED1; index=0; overflow=0; pend_ovf=0. Next state EMIT. term_out=SEED0 and term_valid_out=1 from the next cycle (1-cycle latency).
  - EMIT: term_out and index_out held stable while term_valid_out=1 and term_ready_in=0. On an edge with valid & ready:
    - valid drops.
    - sum = a + b computed at DATA_WIDTH+1 bits; a<=b; b<=sum[DATA_WIDTH-1:0]; a carry sets pend_ovf.
    - If pend_ovf was already set before this handshake (the accepted term was the last representable one): overflow_out<=1, then mode=1 -> HALT; mode=0 -> reload a=SEED0, b=SEED1, pend_ovf=0, index wraps to 0, continue to WAIT.
    - Otherwise -> WAIT with timer=period.
  - WAIT: timer decrements each cycle. When timer==0: term_out<=a, index++, valid<=1 -> EMIT. With period=0, the next term is valid 1 cycle after the handshake; with period=N, N+1 cycles after.
  - HALT: valid=0, busy=0; term_out/index_out hold the last term; overflow_out=1. start_in -> same as from IDLE.
- stop_in=1 in any state: next edge -> IDLE; valid=0; busy=0; term_out/index_out hold; overflow_out holds.
- start_in in EMIT/WAIT: ignored. start and stop in the same cycle: stop wins.
- Only ready is sampled in EMIT; term_valid_out never drops without a handshake except via stop/reset.
- Overflow_out is cleared only by start or reset.
- Async reset mid-handshake: outputs go to reset values immediately.

Optional Feature:
- Macro FIB_SEQ_LED_EN.
- Defined: adds output led_out[3:0] = registered term_out[3:0], updated whenever term_out updates; reset 0.
- Undefined: port and logic absent; core behaviour unchanged.

Decomposition:
- Shared package fib_pkg:
  - state encoding constants ST_IDLE, ST_EMIT, ST_WAIT, ST_HALT (2-bit);
  - mode constants MODE_WRAP=0, MODE_HALT=1.
- Sub-module fib_tick_timer (TICK_WIDTH param):
  - load_in, value_in, expire_out;
  - async active-low reset;
  - replaces the discrete t0/t1/t2 timers.
- Term registers (a, b) use gen_reg.

Test Plan:
- Reset then start, period=0, ready held 1, DATA_WIDTH=8 -> terms 0,1,1,2,3,5,8,13,21,34,55,89,144,233 at index 0..13, one per 2 cycles; after 233 handshake overflow_out=1.
- Same with mode=1 -> after 233, state HALT, valid=0, busy=0, term_out=233, index=13; start again -> term 0, index 0, overflow_out=0.
- mode=0 overflow -> after 233 the next term is 0 with index 0, overflow_out stays 1, sequence continues 1,1,2.
- period=5, ready=1 -> valid re-asserts exactly 6 cycles after each handshake; ready held 0 for 10 cycles -> term_out/index stable, valid stays 1.
- stop_in pulse in WAIT and in EMIT (valid=1) -> IDLE next cycle, valid=0; start+stop same cycle -> stays IDLE.
- Async reset asserted mid-EMIT -> all outputs 0 without waiting for a clock edge; with FIB_SEQ_LED_EN, led_out tracks term_out[3:0] (term 13 -> 4'hD).
